sr_gate: RTL and testbench

Clocked set/reset storage element with NOR-latch semantics, providing complementary outputs Q and Qbar. Set/reset requests are sampled on the clock, optionally through an input synchronizer. The forbidden S=R=1 combination is reported on an `illegal` flag. It is a leaf primitive used wherever a single bit must be set by one event and cleared by another.

---
 rtl/sr_pkg.sv | 15 +
 rtl/sr_sync.sv | 34 +++
 rtl/sr_gate.sv | 76 +++++++
 tb/tb_sr_gate.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the clocked set/reset gate: command encoding and
// output reset values.
package sr_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_FORBID = 2'b11
  } cmd_e;

  localparam logic Q_RST    = 1'b0;
  localparam logic QBAR_RST = 1'b1;

endpackage

// File: rtl/sr_sync.sv
// Parameterised-depth 2-bit flop synchronizer with asynchronous reset;
// depth 0 is a straight wire.
module sr_sync #(
  parameter int DEPTH = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
    // clk/rst have no load in the bypass build; fold them into a named sink.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end else begin : g_chain
    logic [DEPTH-1:0][1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/sr_gate.sv
// Clocked set/reset storage element with NOR-latch output semantics and an
// illegal flag for the S=R=1 command.
module sr_gate
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qbar,
  output logic illegal
);

  logic [1:0] sync_cmd;
  cmd_e       cmd;

  logic q_q, q_d;
  logic qbar_q, qbar_d;
  logic illegal_q, illegal_d;

  sr_sync #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({S, R}),
    .q_o (sync_cmd)
  );

  assign cmd = cmd_e'(sync_cmd);

  // HOLD after FORBIDDEN reads the registered pair, which is not
  // complementary; rebuild it from q_q so the stored state counts as cleared.
  always_comb begin
    q_d       = q_q;
    qbar_d    = ~q_q;
    illegal_d = 1'b0;
    case (cmd)
      CMD_SET: begin
        q_d    = 1'b1;
        qbar_d = 1'b0;
      end
      CMD_RESET: begin
        q_d    = 1'b0;
        qbar_d = 1'b1;
      end
      CMD_FORBID: begin
        q_d       = 1'b0;
        qbar_d    = 1'b0;
        illegal_d = 1'b1;
      end
      default: begin
        q_d    = q_q;
        qbar_d = ~q_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= Q_RST;
      qbar_q    <= QBAR_RST;
      illegal_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      qbar_q    <= qbar_d;
      illegal_q <= illegal_d;
    end
  end

  assign Q       = q_q;
  assign Qbar    = qbar_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_sr_gate.sv
// Self-checking bench for sr_gate: a direct-sampling instance and a
// two-stage-synchronizer instance share the same S/R/rst stimulus.
module tb_sr_gate;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic S   = 1'b0;
  logic R   = 1'b0;

  logic q0, qbar0, ill0;
  logic q2, qbar2, ill2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the command seen at an edge is the one applied
  // SYNC_STAGES edges earlier; the stored bit plus a forbidden flag decide
  // the outputs.
  logic       st0, il0, st2, il2;
  logic [1:0] pipe0[$];
  logic [1:0] pipe2[$];

  sr_gate #(.SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst(rst), .S(S), .R(R), .Q(q0), .Qbar(qbar0), .illegal(ill0)
  );

  sr_gate #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .S(S), .R(R), .Q(q2), .Qbar(qbar2), .illegal(ill2)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] apply_cmd(input logic [1:0] c, input logic st,
                                           input logic il);
    // returns {stored, forbidden}
    case (c)
      2'b10:   return 2'b10;
      2'b01:   return 2'b00;
      2'b11:   return 2'b01;
      default: return {st, 1'b0};
    endcase
  endfunction

  function automatic logic [2:0] exp_out(input logic st, input logic il);
    if (il) return 3'b001;
    return {st, ~st, 1'b0};
  endfunction

  task automatic model_reset();
    st0 = 1'b0; il0 = 1'b0;
    st2 = 1'b0; il2 = 1'b0;
    pipe0.delete();
    pipe2.delete();
    pipe2.push_back(2'b00);
    pipe2.push_back(2'b00);
  endtask

  task automatic model_edge();
    logic [1:0] c;
    pipe0.push_back({S, R});
    pipe2.push_back({S, R});
    c = pipe0.pop_front();
    {st0, il0} = apply_cmd(c, st0, il0);
    c = pipe2.pop_front();
    {st2, il2} = apply_cmd(c, st2, il2);
  endtask

  // Drive one command, let one edge pass, settle 1 time unit after the edge.
  task automatic step(input logic [1:0] c);
    {S, R} = c;
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic test_reset();
    S = 1'b1; R = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({q0, qbar0, ill0} !== 3'b010) begin
      n_fail++; $display("FAIL reset_immediate_d0 got=%b exp=010", {q0, qbar0, ill0});
    end
    n_checks++;
    if ({q2, qbar2, ill2} !== 3'b010) begin
      n_fail++; $display("FAIL reset_immediate_d2 got=%b exp=010", {q2, qbar2, ill2});
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b11);
      n_checks++;
      if ({q0, qbar0, ill0} !== 3'b010) begin
        n_fail++; $display("FAIL reset_held_d0 cyc=%0d got=%b exp=010", i, {q0, qbar0, ill0});
      end
      n_checks++;
      if ({q2, qbar2, ill2} !== 3'b010) begin
        n_fail++; $display("FAIL reset_held_d2 cyc=%0d got=%b exp=010", i, {q2, qbar2, ill2});
      end
    end
    S = 1'b0; R = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'b00);
      n_checks++;
      if ({q0, qbar0, ill0} !== 3'b010) begin
        n_fail++; $display("FAIL reset_release_d0 cyc=%0d got=%b exp=010", i, {q0, qbar0, ill0});
      end
      n_checks++;
      if ({q2, qbar2, ill2} !== 3'b010) begin
        n_fail++; $display("FAIL reset_release_d2 cyc=%0d got=%b exp=010", i, {q2, qbar2, ill2});
      end
    end
  endtask

  task automatic test_set_hold_reset();
    logic [1:0] cmds[5];
    logic [1:0] exp_qq[5];
    cmds   = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    exp_qq = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 5; i++) begin
      step(cmds[i]);
      n_checks++;
      if ({q0, qbar0, ill0} !== {exp_qq[i], 1'b0}) begin
        n_fail++;
        $display("FAIL set_hold_reset_d0 idx=%0d got=%b exp=%b", i, {q0, qbar0, ill0}, {exp_qq[i], 1'b0});
      end
      n_checks++;
      if ({q2, qbar2, ill2} !== exp_out(st2, il2)) begin
        n_fail++;
        $display("FAIL set_hold_reset_d2 idx=%0d got=%b exp=%b", i, {q2, qbar2, ill2}, exp_out(st2, il2));
      end
    end
  endtask

  task automatic test_forbidden();
    logic [1:0] cmds[5];
    logic [2:0] exp0[5];
    cmds = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10};
    exp0 = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100};
    step(2'b10);
    n_checks++;
    if ({q0, qbar0, ill0} !== 3'b100) begin
      n_fail++; $display("FAIL forbid_pre_set got=%b exp=100", {q0, qbar0, ill0});
    end
    for (int i = 0; i < 5; i++) begin
      step(cmds[i]);
      n_checks++;
      if ({q0, qbar0, ill0} !== exp0[i]) begin
        n_fail++; $display("FAIL forbid_exit_d0 idx=%0d got=%b exp=%b", i, {q0, qbar0, ill0}, exp0[i]);
      end
      n_checks++;
      if ({q2, qbar2, ill2} !== exp_out(st2, il2)) begin
        n_fail++;
        $display("FAIL forbid_exit_d2 idx=%0d got=%b exp=%b", i, {q2, qbar2, ill2}, exp_out(st2, il2));
      end
    end
  endtask

  task automatic test_latency();
    logic [2:0] exp_q2;
    for (int i = 0; i < 4; i++) step(2'b01);
    S = 1'b1; R = 1'b0;
    #1;
    n_checks++;
    if (q2 !== 1'b0 || q0 !== 1'b0) begin
      n_fail++; $display("FAIL latency_no_comb got q0=%b q2=%b exp=0,0", q0, q2);
    end
    exp_q2 = 3'b100;  // Q of dut2 after edges 1,2,3 (msb = edge 3)
    for (int e = 0; e < 3; e++) begin
      step(e == 0 ? 2'b10 : 2'b00);
      n_checks++;
      if (q2 !== exp_q2[e]) begin
        n_fail++; $display("FAIL latency_d2 edge=%0d got=%b exp=%b", e + 1, q2, exp_q2[e]);
      end
      n_checks++;
      if ({q2, qbar2, ill2} !== exp_out(st2, il2)) begin
        n_fail++;
        $display("FAIL latency_model_d2 edge=%0d got=%b exp=%b", e + 1, {q2, qbar2, ill2}, exp_out(st2, il2));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(2'b10);
    n_checks++;
    if ({q0, q2} !== 2'b11) begin
      n_fail++; $display("FAIL async_pre_set got q0=%b q2=%b exp=1,1", q0, q2);
    end
    S = 1'b0; R = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({q0, qbar0, ill0, q2, qbar2, ill2} !== 6'b010010) begin
      n_fail++;
      $display("FAIL async_reset_now got=%b exp=010010", {q0, qbar0, ill0, q2, qbar2, ill2});
    end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(2'b00);
      n_checks++;
      if ({q0, qbar0, ill0} !== 3'b010) begin
        n_fail++; $display("FAIL async_hold_d0 cyc=%0d got=%b exp=010", i, {q0, qbar0, ill0});
      end
      n_checks++;
      if ({q2, qbar2, ill2} !== 3'b010) begin
        n_fail++; $display("FAIL async_hold_d2 cyc=%0d got=%b exp=010", i, {q2, qbar2, ill2});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      step(2'($urandom_range(0, 3)));
      n_checks++;
      if ({q0, qbar0, ill0} !== exp_out(st0, il0)) begin
        n_fail++; $display("FAIL random_d0 cyc=%0d got=%b exp=%b", i, {q0, qbar0, ill0}, exp_out(st0, il0));
      end
      n_checks++;
      if ({q2, qbar2, ill2} !== exp_out(st2, il2)) begin
        n_fail++; $display("FAIL random_d2 cyc=%0d got=%b exp=%b", i, {q2, qbar2, ill2}, exp_out(st2, il2));
      end
      n_checks++;
      if (ill0 ? ({q0, qbar0} !== 2'b00) : (qbar0 !== ~q0)) begin
        n_fail++; $display("FAIL invariant_d0 cyc=%0d got q=%b qbar=%b ill=%b", i, q0, qbar0, ill0);
      end
      n_checks++;
      if (ill2 ? ({q2, qbar2} !== 2'b00) : (qbar2 !== ~q2)) begin
        n_fail++; $display("FAIL invariant_d2 cyc=%0d got q=%b qbar=%b ill=%b", i, q2, qbar2, ill2);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_set_hold_reset();
    test_forbidden();
    test_latency();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
